// File: rtl/wbuff_load_sched.sv
// Weight-buffer bank sequencer: streams fill words into the SRAM and reads a run of taps per command.
// Reads start the cycle after acceptance, load pulses follow each read by one cycle; fill is never backpressured.
module wbuff_load_sched #(
    parameter int NB_TAPS           = 11,
    parameter int MAX_TAPS          = 3,
    parameter int BUFFER_DEPTH      = 72,
    parameter int BUFFER_WIDTH      = 16,
    parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_DEPTH),
    parameter int NTAPS_WIDTH       = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [BUFFER_ADDR_WIDTH-1:0] i_cmd_base_addr,
    input  logic [NTAPS_WIDTH-1:0]       i_cmd_ntaps,
    input  logic                         i_cmd_clear,
    input  logic [3:0]                   i_cmd_n_ap,
    output logic                         o_cmd_err,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic                         i_fill_valid,
    input  logic [BUFFER_WIDTH-1:0]      i_fill_data,
    input  logic                         i_fill_restart,
    output logic [BUFFER_ADDR_WIDTH:0]   o_fill_level,
    output logic                         o_buffer_wEn,
    output logic [BUFFER_ADDR_WIDTH-1:0] o_wAddr,
    output logic [BUFFER_WIDTH-1:0]      o_buffer_data_in,
    output logic                         o_buffer_rEn,
    output logic [BUFFER_ADDR_WIDTH-1:0] o_rAddr,
    output logic [NB_TAPS-1:0]           o_weight_load_en,
    output logic                         o_clear_all_wregs,
    output logic [3:0]                   o_n_ap
);

    localparam int AW = BUFFER_ADDR_WIDTH;
    localparam int LW = BUFFER_ADDR_WIDTH + 1;
    localparam logic [LW-1:0]          DEPTH_L = LW'(BUFFER_DEPTH);
    localparam logic [AW-1:0]          LAST_A  = AW'(BUFFER_DEPTH - 1);
    localparam logic [NTAPS_WIDTH-1:0] MAX_N   = NTAPS_WIDTH'(MAX_TAPS);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                  r_state, w_state_nxt;
    logic [AW-1:0]           r_rd_addr;
    logic [NTAPS_WIDTH-1:0]  r_k, r_n;
    logic [3:0]              r_n_ap;
    logic                    r_done, r_err, r_clear;
    logic [NB_TAPS-1:0]      r_load_en;
    logic                    r_buffer_wEn;
    logic [AW-1:0]           r_wAddr, r_wr_ptr;
    logic [BUFFER_WIDTH-1:0] r_wdata;
    logic [LW-1:0]           r_fill_level;

    logic                    w_accept, w_bad_base, w_start;
    logic [NTAPS_WIDTH-1:0]  w_n;
    logic                    w_stall, w_rd_issue;
    logic [AW-1:0]           w_ptr_base;
    logic [LW-1:0]           w_lvl_base;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == LAST_A) ? '0 : a + AW'(1);
    endfunction

    assign w_accept   = i_cmd_valid && (r_state == S_IDLE);
    assign w_bad_base = {1'b0, i_cmd_base_addr} >= DEPTH_L;
    assign w_start    = w_accept && !w_bad_base;
    assign w_n        = (i_cmd_ntaps > MAX_N) ? MAX_N : i_cmd_ntaps;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = (w_n == '0) ? S_DRAIN : S_READ;
            S_READ:  if (w_rd_issue && ((r_k + NTAPS_WIDTH'(1)) == r_n)) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A read colliding with the write on the port this cycle would see stale data; hold it one cycle.
    always_comb begin
        w_stall      = !r_buffer_wEn && (r_wAddr == r_rd_addr);
        w_rd_issue   = (r_state == S_READ) && !w_stall;
        o_cmd_ready  = (r_state == S_IDLE);
        o_busy       = (r_state != S_IDLE);
        o_buffer_rEn = !w_rd_issue;
        o_rAddr      = r_rd_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_addr <= '0;
            r_k       <= '0;
            r_n       <= '0;
            r_n_ap    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clear   <= 1'b0;
            r_load_en <= '0;
        end else begin
            if (w_start) begin
                r_rd_addr <= i_cmd_base_addr;
                r_k       <= '0;
                r_n       <= w_n;
                r_n_ap    <= i_cmd_n_ap;
            end else if (w_rd_issue) begin
                r_rd_addr <= addr_inc(r_rd_addr);
                r_k       <= r_k + NTAPS_WIDTH'(1);
            end
            r_done    <= (r_state == S_DRAIN);
            r_err     <= w_accept && w_bad_base;
            r_clear   <= w_start && i_cmd_clear;
            r_load_en <= w_rd_issue ? (NB_TAPS'(1) << r_k) : '0;
        end
    end

    assign w_ptr_base = i_fill_restart ? '0 : r_wr_ptr;
    assign w_lvl_base = i_fill_restart ? '0 : r_fill_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buffer_wEn <= 1'b1;
            r_wAddr      <= '0;
            r_wdata      <= '0;
            r_wr_ptr     <= '0;
            r_fill_level <= '0;
        end else if (i_fill_valid) begin
            r_buffer_wEn <= 1'b0;
            r_wAddr      <= w_ptr_base;
            r_wdata      <= i_fill_data;
            r_wr_ptr     <= addr_inc(w_ptr_base);
            r_fill_level <= (w_lvl_base < DEPTH_L) ? w_lvl_base + LW'(1) : w_lvl_base;
        end else begin
            r_buffer_wEn <= 1'b1;
            r_wr_ptr     <= w_ptr_base;
            r_fill_level <= w_lvl_base;
        end
    end

    assign o_done            = r_done;
    assign o_cmd_err         = r_err;
    assign o_clear_all_wregs = r_clear;
    assign o_weight_load_en  = r_load_en;
    assign o_n_ap            = r_n_ap;
    assign o_buffer_wEn      = r_buffer_wEn;
    assign o_wAddr           = r_wAddr;
    assign o_buffer_data_in  = r_wdata;
    assign o_fill_level      = r_fill_level;

endmodule

// File: tb/tb_wbuff_load_sched.sv
// Directed bench for wbuff_load_sched: fill, commands, clamp, error, hazard stall, restart and mid-run reset.
module tb_wbuff_load_sched;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_clear, cmd_err, busy, done;
    logic [6:0]  cmd_base_addr;
    logic [3:0]  cmd_ntaps, cmd_n_ap, n_ap;
    logic        fill_valid, fill_restart;
    logic [15:0] fill_data, buffer_data_in;
    logic [7:0]  fill_level;
    logic        buffer_wEn, buffer_rEn, clear_all_wregs;
    logic [6:0]  wAddr, rAddr;
    logic [10:0] weight_load_en;

    int n_cmp = 0;
    int n_err = 0;

    wbuff_load_sched dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_base_addr  (cmd_base_addr),
        .i_cmd_ntaps      (cmd_ntaps),
        .i_cmd_clear      (cmd_clear),
        .i_cmd_n_ap       (cmd_n_ap),
        .o_cmd_err        (cmd_err),
        .o_busy           (busy),
        .o_done           (done),
        .i_fill_valid     (fill_valid),
        .i_fill_data      (fill_data),
        .i_fill_restart   (fill_restart),
        .o_fill_level     (fill_level),
        .o_buffer_wEn     (buffer_wEn),
        .o_wAddr          (wAddr),
        .o_buffer_data_in (buffer_data_in),
        .o_buffer_rEn     (buffer_rEn),
        .o_rAddr          (rAddr),
        .o_weight_load_en (weight_load_en),
        .o_clear_all_wregs(clear_all_wregs),
        .o_n_ap           (n_ap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] base, input logic [3:0] nt, input logic clr, input logic [3:0] nap);
        cmd_valid     = 1'b1;
        cmd_base_addr = base;
        cmd_ntaps     = nt;
        cmd_clear     = clr;
        cmd_n_ap      = nap;
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_base_addr = '0; cmd_ntaps = '0;
        cmd_clear = 1'b0; cmd_n_ap = '0; fill_valid = 1'b0; fill_data = '0; fill_restart = 1'b0;
        #23;
        chk("rst_wEn",   32'(buffer_wEn),      32'd1);
        chk("rst_rEn",   32'(buffer_rEn),      32'd1);
        chk("rst_wAddr", 32'(wAddr),           32'd0);
        chk("rst_rAddr", 32'(rAddr),           32'd0);
        chk("rst_wdata", 32'(buffer_data_in),  32'd0);
        chk("rst_load",  32'(weight_load_en),  32'd0);
        chk("rst_clear", 32'(clear_all_wregs), 32'd0);
        chk("rst_done",  32'(done),            32'd0);
        chk("rst_err",   32'(cmd_err),         32'd0);
        chk("rst_busy",  32'(busy),            32'd0);
        chk("rst_nap",   32'(n_ap),            32'd0);
        chk("rst_level", 32'(fill_level),      32'd0);
        chk("rst_ready", 32'(cmd_ready),       32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Fill 0x0001..0x0048 into addresses 0..71
        for (int i = 0; i < 72; i++) begin
            fill_valid = 1'b1;
            fill_data  = 16'(i + 1);
            tick();
            chk("fill_wEn",   32'(buffer_wEn),     32'd0);
            chk("fill_wAddr", 32'(wAddr),          32'(i));
            chk("fill_wdata", 32'(buffer_data_in), 32'(i + 1));
        end
        chk("fill_level72", 32'(fill_level), 32'd72);
        fill_data = 16'h0049;
        tick();
        chk("wrap_wAddr", 32'(wAddr),      32'd0);
        chk("sat_level",  32'(fill_level), 32'd72);
        fill_valid = 1'b0;
        tick();
        chk("idle_wEn", 32'(buffer_wEn), 32'd1);

        // base=10 ntaps=3 clear n_ap=5
        issue(7'd10, 4'd3, 1'b1, 4'd5);
        chk("c1_clear", 32'(clear_all_wregs), 32'd1);
        chk("c1_rEn",   32'(buffer_rEn),      32'd0);
        chk("c1_rAddr", 32'(rAddr),           32'd10);
        chk("c1_busy",  32'(busy),            32'd1);
        chk("c1_load",  32'(weight_load_en),  32'd0);
        tick();
        chk("c2_clear", 32'(clear_all_wregs), 32'd0);
        chk("c2_rAddr", 32'(rAddr),           32'd11);
        chk("c2_load",  32'(weight_load_en),  32'h001);
        chk("c2_nap",   32'(n_ap),            32'd5);
        tick();
        chk("c3_rEn",   32'(buffer_rEn),      32'd0);
        chk("c3_rAddr", 32'(rAddr),           32'd12);
        chk("c3_load",  32'(weight_load_en),  32'h002);
        tick();
        chk("c4_rEn",   32'(buffer_rEn),      32'd1);
        chk("c4_load",  32'(weight_load_en),  32'h004);
        chk("c4_done",  32'(done),            32'd0);
        chk("c4_busy",  32'(busy),            32'd1);
        tick();
        chk("c5_done",  32'(done),            32'd1);
        chk("c5_ready", 32'(cmd_ready),       32'd1);
        chk("c5_busy",  32'(busy),            32'd0);
        chk("c5_load",  32'(weight_load_en),  32'd0);
        tick();
        chk("c6_done",  32'(done),            32'd0);

        // base=70 ntaps=5 clamps to 3 and wraps
        issue(7'd70, 4'd5, 1'b0, 4'd9);
        chk("w1_rAddr", 32'(rAddr),           32'd70);
        chk("w1_clear", 32'(clear_all_wregs), 32'd0);
        tick();
        chk("w2_rAddr", 32'(rAddr),           32'd71);
        chk("w2_load",  32'(weight_load_en),  32'h001);
        tick();
        chk("w3_rAddr", 32'(rAddr),           32'd0);
        chk("w3_rEn",   32'(buffer_rEn),      32'd0);
        chk("w3_load",  32'(weight_load_en),  32'h002);
        tick();
        chk("w4_rEn",   32'(buffer_rEn),      32'd1);
        chk("w4_load",  32'(weight_load_en),  32'h004);
        tick();
        chk("w5_done",  32'(done),            32'd1);
        chk("w5_load",  32'(weight_load_en),  32'd0);
        chk("w5_nap",   32'(n_ap),            32'd9);

        // base=72 rejected
        tick();
        issue(7'd72, 4'd2, 1'b1, 4'd3);
        chk("e1_err",   32'(cmd_err),         32'd1);
        chk("e1_rEn",   32'(buffer_rEn),      32'd1);
        chk("e1_busy",  32'(busy),            32'd0);
        chk("e1_clear", 32'(clear_all_wregs), 32'd0);
        chk("e1_nap",   32'(n_ap),            32'd9);
        tick();
        chk("e2_err",   32'(cmd_err),         32'd0);
        chk("e2_rEn",   32'(buffer_rEn),      32'd1);
        chk("e2_done",  32'(done),            32'd0);

        // ntaps=0 with clear
        issue(7'd5, 4'd0, 1'b1, 4'd2);
        chk("z1_clear", 32'(clear_all_wregs), 32'd1);
        chk("z1_busy",  32'(busy),            32'd1);
        chk("z1_rEn",   32'(buffer_rEn),      32'd1);
        tick();
        chk("z2_done",  32'(done),            32'd1);
        chk("z2_clear", 32'(clear_all_wregs), 32'd0);
        chk("z2_load",  32'(weight_load_en),  32'd0);
        chk("z2_nap",   32'(n_ap),            32'd2);
        tick();

        // fill_restart with fill_valid
        fill_restart = 1'b1; fill_valid = 1'b1; fill_data = 16'hAAAA;
        tick();
        fill_restart = 1'b0;
        chk("rs_wAddr", 32'(wAddr),      32'd0);
        chk("rs_level", 32'(fill_level), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            fill_data = 16'(16'h0100 + i);
            tick();
        end
        fill_valid = 1'b0;
        chk("rs_wAddr10", 32'(wAddr),      32'd10);
        chk("rs_level11", 32'(fill_level), 32'd11);
        tick();

        // Hazard: write to 11 presented in the cycle read 11 is due
        issue(7'd10, 4'd3, 1'b0, 4'd7);
        chk("h1_rAddr", 32'(rAddr),      32'd10);
        chk("h1_rEn",   32'(buffer_rEn), 32'd0);
        fill_valid = 1'b1; fill_data = 16'hBEEF;
        tick();
        fill_valid = 1'b0;
        chk("h2_wEn",   32'(buffer_wEn),     32'd0);
        chk("h2_wAddr", 32'(wAddr),          32'd11);
        chk("h2_rEn",   32'(buffer_rEn),     32'd1);
        chk("h2_load",  32'(weight_load_en), 32'h001);
        tick();
        chk("h3_rEn",   32'(buffer_rEn),     32'd0);
        chk("h3_rAddr", 32'(rAddr),          32'd11);
        chk("h3_load",  32'(weight_load_en), 32'd0);
        tick();
        chk("h4_rAddr", 32'(rAddr),          32'd12);
        chk("h4_load",  32'(weight_load_en), 32'h002);
        chk("h4_done",  32'(done),           32'd0);
        tick();
        chk("h5_load",  32'(weight_load_en), 32'h004);
        chk("h5_done",  32'(done),           32'd0);
        tick();
        chk("h6_done",  32'(done),           32'd1);
        chk("h6_level", 32'(fill_level),     32'd12);
        tick();

        // Reset asserted during READ
        issue(7'd20, 4'd3, 1'b0, 4'd4);
        chk("r1_rEn", 32'(buffer_rEn), 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("r_rEn",   32'(buffer_rEn),     32'd1);
        chk("r_load",  32'(weight_load_en), 32'd0);
        chk("r_busy",  32'(busy),           32'd0);
        chk("r_ready", 32'(cmd_ready),      32'd1);
        chk("r_nap",   32'(n_ap),           32'd0);
        chk("r_level", 32'(fill_level),     32'd0);
        chk("r_rAddr", 32'(rAddr),          32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("r_nodone", 32'(done),           32'd0);
            chk("r_noload", 32'(weight_load_en), 32'd0);
        end
        chk("r_ready_end", 32'(cmd_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wbuff_load_sched.md
Name: wbuff_load_sched

Overview:
- Sequencer for one weight-buffer bank: the 72x16 two-port SRAM, its BPR/ETC encoder and the per-tap weight/BPR/ETC registers.
- Streams incoming weights into the SRAM write port.
- On command, reads a run of consecutive words and pulses the matching one-hot tap load enables, optionally clearing all tap registers first.
- Latches the n_ap encoder configuration per command.
- Sits between the array-level weight loader/controller and the bank.

Parameters:
- nb_taps, 11, width of weight_load_en.
- max_taps, 3, taps physically implemented; longer requests are clamped to this.
- buffer_depth, 72, SRAM words.
- buffer_width, 16, SRAM word width.
- buffer_addr_width, clogb2(buffer_depth), SRAM address width.
- ntaps_width, 4, width of cmd_ntaps.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  load-command request
- cmd_ready  out  1  high when the FSM is IDLE
- cmd_base_addr  in  buffer_addr_width  first SRAM word to read
- cmd_ntaps  in  ntaps_width  number of taps to load
- cmd_clear  in  1  clear all tap registers before loading
- cmd_n_ap  in  4  encoder approximation setting
- cmd_err  out  1  one-cycle pulse: command rejected
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- fill_valid  in  1  fill word present
- fill_data  in  buffer_width  fill word
- fill_restart  in  1  reset write pointer to 0
- fill_level  out  buffer_addr_width+1  words written since restart, saturating at buffer_depth
- buffer_wEn  out  1  SRAM write enable, active-low
- wAddr  out  buffer_addr_width  SRAM write address
- buffer_data_in  out  buffer_width  SRAM write data
- buffer_rEn  out  1  SRAM read enable, active-low
- rAddr  out  buffer_addr_width  SRAM read address
- weight_load_en  out  nb_taps  one-hot tap load pulse
- clear_all_wregs  out  1  one-cycle clear of the tap registers
- n_ap  out  4  encoder setting

Behaviour:
- Reset values: buffer_wEn=1, buffer_rEn=1, wAddr=0, rAddr=0, buffer_data_in=0, weight_load_en=0, clear_all_wregs=0, done=0, cmd_err=0, busy=0, n_ap=0, fill_level=0, write pointer=0. The FSM resets to IDLE, so cmd_ready=1 after reset.
- Reset mid-operation aborts the command with no done pulse. Any pending tap loads are dropped.
- FSM states and transitions:
  - IDLE: accept on cmd_valid&&cmd_ready.
  - If cmd_base_addr>=buffer_depth: pulse cmd_err the next cycle, stay IDLE, leave n_ap unchanged.
  - Otherwise latch N=min(cmd_ntaps,max_taps), base, n_ap=cmd_n_ap, go to READ. If N=0, go to DRAIN instead.
  - READ: issue N reads, then go to DRAIN.
  - DRAIN: wait one cycle, then go to IDLE with done=1 for that cycle.
- Timing, acceptance at cycle 0, no stalls:
  - Cycle 1: clear_all_wregs=1 if cmd_clear.
  - Cycles 1..N: read k (k=0..N-1) drives buffer_rEn=0 and rAddr=(base+k) mod buffer_depth. Wrap from buffer_depth-1 to 0.
  - Cycle k+2: weight_load_en[k]=1. SRAM Q is valid one cycle after the read.
  - Cycle N+2: done=1 and cmd_ready=1.
  - N=0: cycle 1 clear only (if requested); done at cycle 2.
- busy=1 from cycle 1 until the cycle before done.
- weight_load_en bits >= max_taps are always 0. At most one bit is set per cycle.
- Clear and the first tap load never coincide. If cmd_clear=0, clear_all_wregs stays 0.
- n_ap holds its value between commands.
- Fill path:
  - Each cycle with fill_valid=1 registers buffer_wEn=0, wAddr=wr_ptr, buffer_data_in=fill_data. The write lands one cycle later.
  - wr_ptr increments and wraps from buffer_depth-1 to 0.
  - fill_level increments, saturating at buffer_depth.
  - Fill is always accepted; there is no backpressure.
- fill_restart:
  - Sets wr_ptr=0 and fill_level=0.
  - If simultaneous with fill_valid, the word goes to address 0, then wr_ptr=1 and fill_level=1.
- Hazard stall:
  - Applies when a read candidate address equals the address of the write being issued that same cycle.
  - The read is withheld (buffer_rEn=1) for one cycle and retried.
  - Its weight_load_en shifts by the same amount, and done shifts accordingly.
- Fill and command execution proceed concurrently otherwise.

Test Plan:
- Fill 0x0001..0x0048 into addresses 0..71 -> fill_level=72. A 73rd word lands at wAddr=0 and fill_level stays 72.
- Command base=10, ntaps=3, clear=1, n_ap=5, accepted at cycle 0:
  - clear_all_wregs at cycle 1;
  - rAddr 10,11,12 at cycles 1-3;
  - weight_load_en 0x001, 0x002, 0x004 at cycles 2-4;
  - done at cycle 5; n_ap=5.
- base=70, ntaps=5 -> clamped to 3; rAddr 70,71,0; three load pulses; done at cycle 5.
- base=72 -> cmd_err pulse, no reads, n_ap unchanged. ntaps=0 with clear=1 -> clear at cycle 1, done at cycle 2.
- Hazards:
  - fill_valid issuing write to address 11 in the same cycle read 11 is due -> read delayed one cycle; load_en[1] and done each shift by +1.
  - fill_restart together with fill_valid -> write to address 0, fill_level=1.
- rst_n asserted during READ -> all outputs return to reset values immediately; after release cmd_ready=1 and no done pulse occurs.
